// File: rtl/mat_pkg.sv
// Shared matrix dimensions, drain-stage state encoding and index-width helper.
package mat_pkg;

    localparam int unsigned M_DEF = 100;
    localparam int unsigned N_DEF = 100;
    localparam int unsigned W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major row/col walker over an M x N matrix; exposes next indices for look-ahead loads.
module mat_idx_counter
    import mat_pkg::*;
#(
    parameter int unsigned M = M_DEF,
    parameter int unsigned N = N_DEF,
    localparam int unsigned RW = idx_w(M),
    localparam int unsigned CW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last_col,
    output logic          last,
    output logic [RW-1:0] next_row_c,
    output logic [CW-1:0] next_col_c
);

    assign last_col   = (col == CW'(N - 1));
    assign last       = last_col && (row == RW'(M - 1));
    assign next_col_c = last_col ? '0 : col + CW'(1);
    assign next_row_c = last_col ? (last ? '0 : row + RW'(1)) : row;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            row <= next_row_c;
            col <= next_col_c;
        end
    end

endmodule

// File: rtl/mat_stream_out.sv
// Drains the compute block's parallel result matrix as a row-major valid/ready
// element stream with boundary tags and a wrap-around checksum.
module mat_stream_out
    import mat_pkg::*;
#(
    parameter int unsigned M = M_DEF,
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF,
    localparam int unsigned RW = idx_w(M),
    localparam int unsigned CW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  Co [0:M-1][0:N-1],
    input  logic          start,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last_col,
    output logic          out_last,
    output logic          done,
    output logic [W-1:0]  checksum
);

    state_t        state, state_d;
    logic          valid_d, busy_d, done_d;
    logic [W-1:0]  data_d, acc, acc_d, checksum_d;
    logic          inc, clr, xfer;
    logic [RW-1:0] next_row;
    logic [CW-1:0] next_col;

    assign xfer = out_valid && out_ready;

    mat_idx_counter #(
        .M(M),
        .N(N)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inc       (inc),
        .row       (out_row),
        .col       (out_col),
        .last_col  (out_last_col),
        .last      (out_last),
        .next_row_c(next_row),
        .next_col_c(next_col)
    );

    // Next-state and next-output logic; data for the following element is fetched on the accepting edge.
    always_comb begin
        state_d    = state;
        valid_d    = out_valid;
        busy_d     = busy;
        done_d     = 1'b0;
        data_d     = out_data;
        acc_d      = acc;
        checksum_d = checksum;
        inc        = 1'b0;
        clr        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    clr     = 1'b1;
                    data_d  = Co[0][0];
                    acc_d   = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    acc_d = acc + out_data;
                    if (out_last) begin
                        state_d    = DONE;
                        valid_d    = 1'b0;
                        done_d     = 1'b1;
                        checksum_d = acc + out_data;
                    end else begin
                        inc    = 1'b1;
                        data_d = Co[next_row][next_col];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            checksum  <= '0;
        end else begin
            state     <= state_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            out_data  <= data_d;
            acc       <= acc_d;
            checksum  <= checksum_d;
        end
    end

endmodule

// File: doc/mat_stream_out.md
Name: mat_stream_out

Overview:
- Drain stage directly downstream of the matrix compute block `two`.
- Takes that block's parallel result matrix Co (M x N words) and emits it as a row-major element stream over a valid/ready handshake.
- Tags row and matrix boundaries and produces a wrap-around checksum, so results can be moved off-chip or into a checker one element per cycle.

Parameters:
- M, 100, number of rows of Co
- N, 100, number of columns of Co
- W, 32, element width in bits
- RW, $clog2(M) (min 1), row index width, derived
- CW, $clog2(N) (min 1), column index width, derived

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous reset, active-high
- Co  input  W x [0:M-1][0:N-1]  result matrix from compute stage; must stay stable from start acceptance until done
- start  input  1  begin draining; sampled only in IDLE
- busy  output  1  high in STREAM and DONE
- out_valid  output  1  out_data/out_row/out_col/out_last_col/out_last are valid
- out_ready  input  1  consumer accepts the element this cycle
- out_data  output  W  current element Co[out_row][out_col]
- out_row  output  RW  row index of current element
- out_col  output  CW  column index of current element
- out_last_col  output  1  current element has out_col == N-1
- out_last  output  1  current element is Co[M-1][N-1]
- done  output  1  one-cycle pulse after the final transfer
- checksum  output  W  sum of all transferred elements mod 2^W

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE.
  - out_valid, done, busy, out_last_col, out_last = 0.
  - out_data, out_row, out_col, checksum = 0.
  - Reset has priority over every other input, including mid-stream; the partial stream is abandoned and no done is issued.
- States:
  - IDLE: start=1 -> STREAM. Next cycle out_valid=1, out_row=0, out_col=0, out_data=Co[0][0]; the internal accumulator clears to 0. Start-to-first-valid latency is 1 cycle.
  - STREAM: a transfer occurs when out_valid && out_ready.
    - On a non-final transfer: advance col; at col==N-1, col wraps to 0 and row increments. out_data loads the next element in the same edge, and out_valid stays 1. This gives full throughput of 1 element/cycle.
    - With out_ready=0: all out_* outputs hold unchanged.
    - On the final transfer (out_last=1): out_valid falls to 0 and the state moves to DONE.
  - DONE: done=1 for exactly one cycle; checksum updates to its final value in this cycle; the next state is IDLE.
- Checksum:
  - accumulator += out_data on each transfer, truncated to W bits (wraps, no saturation).
  - The checksum output updates only on entry to DONE and holds until the next accepted start's DONE or rst.
- start while busy: ignored and has no effect.
- start in the DONE cycle: ignored; start is re-sampled once back in IDLE.
- out_last_col and out_last are combinational functions of the registered indices, but are presented as registered (aligned with out_data).
- Degenerate M=1 or N=1 is legal. For M=N=1 the first element is also out_last, and a single transfer goes to DONE.
- Minimum cycles from start to done pulse: M*N+1.
- out_valid never drops mid-matrix. Once asserted, data is held until accepted.

Decomposition:
- Package mat_pkg:
  - default M/N/W localparams shared with `two` and its bench.
  - state enum {IDLE, STREAM, DONE}.
  - an index-width helper function.
- One sub-module, mat_idx_counter (parameters M, N):
  - row/col counter with inc and clr inputs.
  - outputs row, col, last_col, last.
  - reused by future loader stages.

Test Plan:
- M=2,N=3,W=32, Co rows {1,2,3},{4,5,6}, out_ready=1, start pulse:
  - out_valid rises 1 cycle after start; data 1,2,3,4,5,6 on consecutive cycles.
  - out_last_col on 3 and 6; out_last on 6 only.
  - done pulses the next cycle with checksum=21.
- Same setup, out_ready=0 for 3 cycles while out_data=3:
  - out_data/out_row/out_col hold at 3/0/2 and out_valid stays 1.
  - The stream resumes with 4; checksum remains 21.
- M=2,N=3,W=8, all elements 8'hFF: checksum=8'hFA (1530 mod 256), proving wrap.
- Default 100x100, Co[i][j]=i*100+j, out_ready=1:
  - 10000 transfers in order.
  - done exactly 10001 cycles after start with checksum=49995000.
- start re-pulsed mid-stream, and at the DONE cycle: no restart and no index change; exactly one done pulse per matrix.
- rst=1 at element 2 of a 2x3 stream:
  - Next cycle all outputs are 0 and there is no done.
  - A subsequent start re-streams from Co[0][0] and yields checksum=21.
